// File: rtl/pong_object_engine_pkg.sv
// Shared constants, types and helpers for the pong object engine.
//  - Screen, ball and paddle geometry, with derived reset and limit positions
//  - RGB565 colour constants
//  - FSM state encoding (ST_IDLE..ST_OVER)
//  - in_span(): inclusive-low / exclusive-high range test used by the pixel compare stage
package pong_object_engine_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int BALL_SIZE    = 8;
  localparam int BALL_STEP    = 2;
  localparam int PADDLE_X     = 16;
  localparam int PADDLE_W     = 8;
  localparam int PADDLE_H     = 64;
  localparam int PADDLE_STEP  = 4;
  localparam int SERVE_FRAMES = 60;
  localparam int MAX_SCORE    = 9;
  localparam int BORDER_LINES = 2;

  // Derived positions and limits
  localparam logic [9:0] BALL_X0      = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y0      = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] PADDLE_Y0    = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0] PADDLE_Y_MAX = 10'(V_ACTIVE - PADDLE_H);

  // Signed 11-bit constants for the ball's next-position arithmetic
  localparam logic signed [10:0] BALL_STEP_S = 11'(BALL_STEP);
  localparam logic signed [10:0] BALL_X_MAX  = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] BALL_Y_MAX  = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] PADDLE_EDGE = 11'(PADDLE_X + PADDLE_W);

  localparam logic [15:0] RGB_BLACK  = 16'h0000;
  localparam logic [15:0] RGB_BALL   = 16'hFFFF;
  localparam logic [15:0] RGB_PADDLE = 16'h07E0;
  localparam logic [15:0] RGB_BORDER = 16'h001F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // True when lo <= pos < lo + len; widened to 11 bits so lo + len cannot wrap.
  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] lo,
                                   input logic [10:0] len);
    logic [10:0] pos_w;
    logic [10:0] lo_w;
    pos_w = {1'b0, pos};
    lo_w  = {1'b0, lo};
    return (pos_w >= lo_w) && (pos_w < (lo_w + len));
  endfunction

endpackage

// File: rtl/pong_pixel_mux.sv
// Two-stage pixel colouring pipeline.
//  S1 registers the ball / paddle / border hit tests and the valid flag for the
//  requested scan position; S2 applies the colour priority and registers the result.
// Ports:
//  clk, rst               pixel clock, synchronous active-high reset (flushes both stages)
//  scan_x, scan_y         requested scan position
//  scan_valid             scan position is inside the active area
//  ball_x, ball_y         ball top-left corner
//  paddle_y               paddle top row (column is fixed)
//  rgb, rgb_valid         RGB565 colour and valid, 2 cycles after scan_x/scan_y
module pong_pixel_mux
  import pong_object_engine_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  scan_x,
  input  logic [9:0]  scan_y,
  input  logic        scan_valid,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [9:0]  paddle_y,
  output logic [15:0] rgb,
  output logic        rgb_valid
);

  logic        s1_valid_d, s1_valid_q;
  logic        s1_ball_d, s1_ball_q;
  logic        s1_paddle_d, s1_paddle_q;
  logic        s1_border_d, s1_border_q;
  logic [15:0] rgb_d, rgb_q;
  logic        rgb_valid_d, rgb_valid_q;

  // S1: object hit tests for the requested position
  always_comb begin
    s1_valid_d  = scan_valid;
    s1_ball_d   = in_span(scan_x, ball_x, 11'(BALL_SIZE)) &&
                  in_span(scan_y, ball_y, 11'(BALL_SIZE));
    s1_paddle_d = in_span(scan_x, 10'(PADDLE_X), 11'(PADDLE_W)) &&
                  in_span(scan_y, paddle_y, 11'(PADDLE_H));
    s1_border_d = (scan_y < 10'(BORDER_LINES)) ||
                  (scan_y >= 10'(V_ACTIVE - BORDER_LINES));
  end

  // S2: colour priority, blanking outside the active area
  always_comb begin
    rgb_valid_d = s1_valid_q;
    if (!s1_valid_q) begin
      rgb_d = RGB_BLACK;
    end else if (s1_ball_q) begin
      rgb_d = RGB_BALL;
    end else if (s1_paddle_q) begin
      rgb_d = RGB_PADDLE;
    end else if (s1_border_q) begin
      rgb_d = RGB_BORDER;
    end else begin
      rgb_d = RGB_BLACK;
    end
  end

  // Pipeline registers for both stages
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_ball_q   <= 1'b0;
      s1_paddle_q <= 1'b0;
      s1_border_q <= 1'b0;
      rgb_q       <= RGB_BLACK;
      rgb_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ball_q   <= s1_ball_d;
      s1_paddle_q <= s1_paddle_d;
      s1_border_q <= s1_border_d;
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end

  assign rgb       = rgb_q;
  assign rgb_valid = rgb_valid_q;

endmodule

// File: rtl/pong_object_engine.sv
// Pong game logic: one paddle, one ball, game FSM and per-pixel colouring.
// Objects move once per frame on the selected vsync edge; pixels are coloured by
// pong_pixel_mux with a fixed 2-cycle latency.
// Ports:
//  iVGA_CLK             pixel clock (only clock)
//  sys_rst              synchronous reset, active-high
//  ivga_x/ivga_y        scan position from vga_draw
//  ivga_valid           scan position inside active area
//  ivga_vsync           vsync from vga_draw
//  ent[0] / ent[1]      start-restart / pause toggle (levels, edge-detected here)
//  iBtn_up / iBtn_dn    paddle up / down (held)
//  oRGB / oRGB_valid    RGB565 colour and valid, 2 cycles after ivga_x/ivga_y
//  oScore               misses so far
//  oState               FSM state (pause shows as PLAY)
module pong_object_engine
  import pong_object_engine_pkg::*;
#(
  parameter bit VSYNC_ACT_LOW = 1'b1
) (
  input  logic        iVGA_CLK,
  input  logic        sys_rst,
  input  logic [9:0]  ivga_x,
  input  logic [9:0]  ivga_y,
  input  logic        ivga_valid,
  input  logic        ivga_vsync,
  input  logic [1:0]  ent,
  input  logic        iBtn_up,
  input  logic        iBtn_dn,
  output logic [15:0] oRGB,
  output logic        oRGB_valid,
  output logic [3:0]  oScore,
  output logic [1:0]  oState
);

  state_e      state_d, state_q;
  logic        pause_d, pause_q;
  logic [5:0]  serve_cnt_d, serve_cnt_q;
  logic [3:0]  score_d, score_q;
  logic [9:0]  ball_x_d, ball_x_q;
  logic [9:0]  ball_y_d, ball_y_q;
  logic        ball_dx_d, ball_dx_q;   // 1: moving toward larger x
  logic        ball_dy_d, ball_dy_q;   // 1: moving toward larger y
  logic [9:0]  paddle_y_d, paddle_y_q;
  logic        vsync_d, vsync_q;
  logic [1:0]  ent_d, ent_q;

  logic        frame_tick, start_rise, pause_rise;
  logic [10:0] paddle_dn_sum;
  logic [9:0]  paddle_next;
  logic signed [10:0] ball_nx, ball_ny;
  logic        paddle_overlap;
  logic [9:0]  ball_x_next, ball_y_next;
  logic        ball_dx_next, ball_dy_next, ball_miss;

  // The vsync delay flop resets to the inactive level, so reset alone never makes a tick.
  assign frame_tick = VSYNC_ACT_LOW ? (vsync_q & ~ivga_vsync) : (~vsync_q & ivga_vsync);
  assign start_rise = ent[0] & ~ent_q[0];
  assign pause_rise = ent[1] & ~ent_q[1];

  // Paddle candidate position for this tick, clamped to the screen
  always_comb begin
    paddle_dn_sum = {1'b0, paddle_y_q} + 11'(PADDLE_STEP);
    if (iBtn_up && !iBtn_dn) begin
      if (paddle_y_q < 10'(PADDLE_STEP)) begin
        paddle_next = 10'd0;
      end else begin
        paddle_next = paddle_y_q - 10'(PADDLE_STEP);
      end
    end else if (iBtn_dn && !iBtn_up) begin
      if (paddle_dn_sum > {1'b0, PADDLE_Y_MAX}) begin
        paddle_next = PADDLE_Y_MAX;
      end else begin
        paddle_next = paddle_dn_sum[9:0];
      end
    end else begin
      paddle_next = paddle_y_q;
    end
  end

  // Ball candidate position; x and y are resolved independently so corners need no special case
  always_comb begin
    ball_nx = ball_dx_q ? ($signed({1'b0, ball_x_q}) + BALL_STEP_S)
                        : ($signed({1'b0, ball_x_q}) - BALL_STEP_S);
    ball_ny = ball_dy_q ? ($signed({1'b0, ball_y_q}) + BALL_STEP_S)
                        : ($signed({1'b0, ball_y_q}) - BALL_STEP_S);
    // Inclusive span overlap of the ball's current rows with the paddle's rows
    paddle_overlap = ({1'b0, ball_y_q} <= ({1'b0, paddle_y_q} + 11'(PADDLE_H - 1))) &&
                     (({1'b0, ball_y_q} + 11'(BALL_SIZE - 1)) >= {1'b0, paddle_y_q});
    ball_miss    = 1'b0;
    ball_dx_next = ball_dx_q;
    ball_dy_next = ball_dy_q;

    if (ball_ny < 11'sd0) begin
      ball_y_next  = 10'd0;
      ball_dy_next = 1'b1;
    end else if (ball_ny > BALL_Y_MAX) begin
      ball_y_next  = 10'(BALL_Y_MAX);
      ball_dy_next = 1'b0;
    end else begin
      ball_y_next  = ball_ny[9:0];
    end

    if (ball_dx_q && (ball_nx > BALL_X_MAX)) begin
      ball_x_next  = 10'(BALL_X_MAX);
      ball_dx_next = 1'b0;
    end else if (!ball_dx_q && (ball_nx <= PADDLE_EDGE) && paddle_overlap) begin
      ball_x_next  = 10'(PADDLE_EDGE);
      ball_dx_next = 1'b1;
    end else if (ball_nx <= 11'sd0) begin
      ball_x_next  = BALL_X0;
      ball_miss    = 1'b1;
    end else begin
      ball_x_next  = ball_nx[9:0];
    end
  end

  // Game FSM and object position updates
  always_comb begin
    state_d     = state_q;
    pause_d     = pause_q;
    serve_cnt_d = serve_cnt_q;
    score_d     = score_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    ball_dx_d   = ball_dx_q;
    ball_dy_d   = ball_dy_q;
    paddle_y_d  = paddle_y_q;
    vsync_d     = ivga_vsync;
    ent_d       = ent;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d     = ST_SERVE;
          serve_cnt_d = 6'd0;
          score_d     = 4'd0;
        end else begin
          state_d     = state_q;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          paddle_y_d = paddle_next;
          ball_x_d   = BALL_X0;
          ball_y_d   = BALL_Y0;
          ball_dx_d  = 1'b1;
          if (serve_cnt_q == 6'(SERVE_FRAMES - 1)) begin
            state_d = ST_PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q + 6'd1;
          end
        end else begin
          serve_cnt_d = serve_cnt_q;
        end
      end
      ST_PLAY: begin
        if (pause_rise) begin
          pause_d = ~pause_q;
        end else begin
          pause_d = pause_q;
        end
        if (frame_tick && !pause_q) begin
          paddle_y_d = paddle_next;
          ball_dy_d  = ball_dy_next;
          if (ball_miss) begin
            ball_x_d    = BALL_X0;
            ball_y_d    = BALL_Y0;
            ball_dx_d   = 1'b1;
            score_d     = score_q + 4'd1;
            serve_cnt_d = 6'd0;
            pause_d     = 1'b0;
            if ((score_q + 4'd1) == 4'(MAX_SCORE)) begin
              state_d = ST_OVER;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            ball_x_d  = ball_x_next;
            ball_y_d  = ball_y_next;
            ball_dx_d = ball_dx_next;
          end
        end else begin
          paddle_y_d = paddle_y_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge iVGA_CLK) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      pause_q     <= 1'b0;
      serve_cnt_q <= 6'd0;
      score_q     <= 4'd0;
      ball_x_q    <= BALL_X0;
      ball_y_q    <= BALL_Y0;
      ball_dx_q   <= 1'b1;
      ball_dy_q   <= 1'b1;
      paddle_y_q  <= PADDLE_Y0;
      vsync_q     <= VSYNC_ACT_LOW;
      ent_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      pause_q     <= pause_d;
      serve_cnt_q <= serve_cnt_d;
      score_q     <= score_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      ball_dx_q   <= ball_dx_d;
      ball_dy_q   <= ball_dy_d;
      paddle_y_q  <= paddle_y_d;
      vsync_q     <= vsync_d;
      ent_q       <= ent_d;
    end
  end

  pong_pixel_mux u_pixel_mux (
    .clk        (iVGA_CLK),
    .rst        (sys_rst),
    .scan_x     (ivga_x),
    .scan_y     (ivga_y),
    .scan_valid (ivga_valid),
    .ball_x     (ball_x_q),
    .ball_y     (ball_y_q),
    .paddle_y   (paddle_y_q),
    .rgb        (oRGB),
    .rgb_valid  (oRGB_valid)
  );

  assign oScore = score_q;
  assign oState = state_q;

endmodule

// File: tb/tb_pong_object_engine.sv
// Randomized scoreboard bench for pong_object_engine.
// A behavioural game model (plain integers) predicts object positions; each valid scan
// pushes its expected colour, and a monitor pops and compares on every oRGB_valid.
module tb_pong_object_engine;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [9:0]  ivga_x, ivga_y;
  logic        ivga_valid, ivga_vsync;
  logic [1:0]  ent;
  logic        iBtn_up, iBtn_dn;
  logic [15:0] oRGB;
  logic        oRGB_valid;
  logic [3:0]  oScore;
  logic [1:0]  oState;

  always #5 clk = ~clk;

  pong_object_engine dut (
    .iVGA_CLK   (clk),
    .sys_rst    (sys_rst),
    .ivga_x     (ivga_x),
    .ivga_y     (ivga_y),
    .ivga_valid (ivga_valid),
    .ivga_vsync (ivga_vsync),
    .ent        (ent),
    .iBtn_up    (iBtn_up),
    .iBtn_dn    (iBtn_dn),
    .oRGB       (oRGB),
    .oRGB_valid (oRGB_valid),
    .oScore     (oScore),
    .oState     (oState)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  // Game model: 0 idle, 1 serve, 2 play, 3 over; dx/dy are +1/-1
  int m_state, m_pause, m_cnt, m_score, bx, by, dx, dy, py;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_pause = 0; m_cnt = 0; m_score = 0;
    bx = 316; by = 236; dx = 1; dy = 1; py = 208;
  endtask

  function automatic logic [15:0] model_pixel(input int x, input int y);
    if (x >= bx && x < bx + 8 && y >= by && y < by + 8) return 16'hFFFF;
    if (x >= 16 && x < 24 && y >= py && y < py + 64) return 16'h07E0;
    if (y < 2 || y >= 478) return 16'h001F;
    return 16'h0000;
  endfunction

  task automatic model_tick(input bit up, input bit dn);
    int old_py, old_by, nx, ny;
    bit move_pad;
    old_py = py;
    old_by = by;
    move_pad = (m_state == 1) || (m_state == 2 && m_pause == 0);
    if (m_state == 1) begin
      if (m_cnt == 59) m_state = 2;
      else m_cnt++;
    end else if (m_state == 2 && m_pause == 0) begin
      nx = bx + 2 * dx;
      ny = by + 2 * dy;
      if (ny < 0) begin by = 0; dy = 1; end
      else if (ny > 472) begin by = 472; dy = -1; end
      else by = ny;
      if (dx > 0 && nx > 632) begin
        bx = 632; dx = -1;
      end else if (dx < 0 && nx <= 24 && old_by <= old_py + 63 && old_by + 7 >= old_py) begin
        bx = 24; dx = 1;
      end else if (nx <= 0) begin
        bx = 316; by = 236; dx = 1;
        m_score++; m_cnt = 0; m_pause = 0;
        m_state = (m_score == 9) ? 3 : 1;
      end else begin
        bx = nx;
      end
    end
    if (move_pad) begin
      if (up && !dn) py = (py - 4 < 0) ? 0 : py - 4;
      else if (dn && !up) py = (py + 4 > 416) ? 416 : py + 4;
    end
  endtask

  // Monitor: every presented pixel is matched against the oldest expectation
  always @(negedge clk) begin
    if (sys_rst === 1'b0 && oRGB_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pixel_extra: got rgb 0x%0h with no pending request", oRGB);
      end else begin
        check("pixel", int'(oRGB), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic scan(input int x, input int y, input bit v);
    @(posedge clk); #1;
    ivga_x = 10'(x);
    ivga_y = 10'(y);
    ivga_valid = v;
    if (v) exp_q.push_back(model_pixel(x, y));
  endtask

  task automatic drain();
    @(posedge clk); #1;
    ivga_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // One frame: random/targeted scans, then a vsync falling edge (one tick)
  task automatic frame(input bit up, input bit dn, input int nscan);
    int x, y, sel;
    @(posedge clk); #1;
    iBtn_up = up;
    iBtn_dn = dn;
    for (int i = 0; i < nscan; i++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0) begin
        x = int'($urandom_range(0, 639));
        y = int'($urandom_range(0, 479));
      end else if (sel == 1) begin
        x = bx - 2 + int'($urandom_range(0, 11));
        y = by - 2 + int'($urandom_range(0, 11));
      end else begin
        x = 14 + int'($urandom_range(0, 11));
        y = py - 2 + int'($urandom_range(0, 67));
      end
      scan(clampi(x, 639), clampi(y, 479), $urandom_range(0, 7) != 0);
    end
    if (nscan > 0) drain();
    @(posedge clk); #1;
    ivga_valid = 1'b0;
    ivga_vsync = 1'b0;
    model_tick(up, dn);
    @(posedge clk); #1;
    ivga_vsync = 1'b1;
    @(negedge clk);
    check("frame_state", int'(oState), m_state);
    check("frame_score", int'(oScore), m_score);
  endtask

  task automatic pulse(input int idx);
    @(posedge clk); #1;
    ent[idx] = 1'b1;
    if (idx == 0) begin
      if (m_state == 0 || m_state == 3) begin
        m_state = 1; m_cnt = 0; m_score = 0;
      end
    end else if (m_state == 2) begin
      m_pause = (m_pause == 0) ? 1 : 0;
    end
    @(posedge clk); #1;
    ent[idx] = 1'b0;
    @(negedge clk);
    check("ent_state", int'(oState), m_state);
    check("ent_score", int'(oScore), m_score);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int frames;
    bit up, dn;
    sys_rst = 1'b1; ivga_x = 10'd0; ivga_y = 10'd0; ivga_valid = 1'b0;
    ivga_vsync = 1'b1; ent = 2'b00; iBtn_up = 1'b0; iBtn_dn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 sys_rst = 1'b0;

    // Traffic, then a 3-clock reset in the middle of a line
    for (int i = 0; i < 10; i++) scan(int'($urandom_range(0, 639)), 240, 1'b1);
    @(posedge clk); #1;
    sys_rst = 1'b1;
    exp_q.delete();
    model_reset();
    for (int i = 0; i < 2; i++) begin
      ivga_x = 10'($urandom_range(0, 639));
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    sys_rst = 1'b0;
    ivga_valid = 1'b0;
    @(negedge clk);
    check("rst_rgb", int'(oRGB), 0);
    check("rst_rgb_valid", int'(oRGB_valid), 0);
    check("rst_state", int'(oState), m_state);
    check("rst_score", int'(oScore), m_score);

    // IDLE picture: ball, paddle, background; no motion even with buttons held
    scan(320, 240, 1'b1);
    scan(20, 240, 1'b1);
    scan(100, 100, 1'b1);
    scan(300, 0, 1'b1);
    scan(300, 479, 1'b1);
    drain();
    frame(1'b1, 1'b0, 20);
    frame(1'b0, 1'b1, 20);

    // Start, then 60 frames of serve with up held: paddle runs to 0 and stays
    pulse(0);
    for (int i = 0; i < 60; i++) frame(1'b1, 1'b0, (i % 8 == 7) ? 16 : 0);
    frame(1'b1, 1'b1, 16);
    frame(1'b0, 1'b0, 24);

    // Random play until game over
    frames = 0;
    while (m_state != 3 && frames < 12000) begin
      up = 1'($urandom_range(0, 1));
      dn = 1'($urandom_range(0, 1));
      frame(up, dn, (frames % 32 == 0) ? 24 : 0);
      if (frames == 40) begin
        pulse(1);
        frame(1'b1, 1'b0, 24);
        frame(1'b0, 1'b1, 24);
        pulse(1);
      end
      frames++;
    end
    if (m_state != 3) begin
      n_checks++;
      $display("FAIL game_over_timeout: state %0d score %0d after %0d frames", m_state, m_score, frames);
    end

    // Frozen after game over, then restart
    frame(1'b1, 1'b0, 24);
    frame(1'b0, 1'b1, 24);
    pulse(0);
    frame(1'b0, 1'b1, 24);
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
